vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA raster timing generator for the DE0-Nano text/graphics path. It produces the pixel coordinates `PIXEL_H`/`PIXEL_V` that the text renderers consume, and takes back their 3-bit `PIXEL` colour. It drives the display-side `hsync`, `vsync` and `rgb`, delayed so they stay aligned with the renderer's font-ROM read latency. It sits between the 50 MHz board clock and the VGA connector, one instance per display.

## Interface
Parameters:
- `CLK_DIV`, 2: `clk` cycles per pixel; the pixel rate is clk/CLK_DIV. Must be ≥1.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: active level of `hsync`/`vsync`.
- `PIPE_DELAY`, 1: renderer latency in pixel ticks, range 0..4.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous reset, active-high.
- `PIXEL`  in  3  renderer colour {R,G,B} for the coordinate issued PIPE_DELAY ticks earlier.
- `PIXEL_H`  out  11  current horizontal count, 0..H_TOTAL-1.
- `PIXEL_V`  out  11  current vertical count, 0..V_TOTAL-1.
- `pixel_tick`  out  1  one-clk strobe; coordinates advance on this edge.
- `frame_start`  out  1  one-clk pulse when the count wraps to (0,0).
- `hsync`  out  1  delayed horizontal sync.
- `vsync`  out  1  delayed vertical sync.
- `video_on`  out  1  delayed visible-area flag.
- `rgb`  out  3  colour to the DAC; forced to 0 outside the visible area.

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK, which is 800 with the defaults. V_TOTAL = sum of the V parameters, which is 525.
- Divider `div_cnt`:
  - counts 0..CLK_DIV-1 and then wraps;
  - `pixel_tick` = (div_cnt == CLK_DIV-1), combinational from a register;
  - when CLK_DIV=1, `pixel_tick` is held at 1.
- On each tick:
  - h increments, wrapping from H_TOTAL-1 to 0;
  - when h wraps, v increments, wrapping from V_TOTAL-1 to 0;
  - both counters are unsigned 11-bit and never exceed TOTAL-1.
- `PIXEL_H`/`PIXEL_V` are the counter registers themselves.
- Undelayed flags:
  - h_sync_raw is active when H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751;
  - v_sync_raw is active when v is 490..491;
  - vis_raw = h<H_VISIBLE && v<V_VISIBLE.
- The three raw flags pass through a PIPE_DELAY-stage shift register that advances only on `pixel_tick`. Its outputs are `hsync`, `vsync` and `video_on`. The sync outputs are driven at level SYNC_POL when active, ~SYNC_POL otherwise.
- `rgb` is registered on the tick: `rgb` ← delayed vis ? `PIXEL` : 3'b000.
- `frame_start` = 1 for the single clk in which the tick edge moves the counters to (0,0).
- Reset values, applied asynchronously while `reset` is high:
  - div_cnt=0, h=0, v=0;
  - delay stages hold inactive flags;
  - `hsync`=`vsync`=~SYNC_POL;
  - `video_on`=0, `rgb`=0, `frame_start`=0.
- Reset asserted mid-frame aborts the frame immediately. After release the raster restarts at (0,0) with no `frame_start` pulse for that first frame.

## Timing
- After `reset` falls, the first tick occurs in clk cycle CLK_DIV-1, counting from 0. `PIXEL_H` becomes 1 at that edge.
- Each coordinate is stable for exactly CLK_DIV clks.
- The renderer must drive `PIXEL` for coordinate N before the tick edge that ends tick period N+PIPE_DELAY. A synchronous font ROM with 1-clk read latency satisfies this with PIPE_DELAY=1 and CLK_DIV=2.
- Latency from a coordinate to the matching `rgb`/`hsync`/`vsync`/`video_on` is PIPE_DELAY+1 ticks; all four outputs stay mutually aligned.
- Line period is H_TOTAL·CLK_DIV = 1600 clk. Frame period is 840000 clk.
- With PIPE_DELAY=0, the flags are registered once, i.e. 1-tick latency, matching `rgb`.

## Structure
- Package `vga_timing_pkg` holds:
  - default timing constants for 640x480@60;
  - H_TOTAL/V_TOTAL derivation functions;
  - a sync-polarity constant.
- Sub-module `sync_delay_line`: parameterised depth and width, tick-enabled shift register with asynchronous clear. It is instantiated once, at width 3.

## Test plan
- Reset with `reset` held 5 clks → all outputs at reset values, `hsync`=`vsync`=1, `rgb`=0. After release, `PIXEL_H` steps 0→1→2 every 2 clks.
- Run one full frame → `PIXEL_H` wraps 799→0 and `PIXEL_V` increments. `frame_start` pulses once at (799,524)→(0,0), 840000 clks apart.
- Sync width check → `hsync` low for exactly 96 ticks starting 2 ticks after h=656. `vsync` low for exactly 2 lines starting at v=490 (plus the delay).
- Drive `PIXEL`=3'b101 constantly → `rgb`=101 for exactly 640 ticks per visible line and 0 in the blanking and vertical-blank lines.
- Drive `PIXEL` = h[2:0] registered with 1-clk latency → `rgb` at visible column 0 equals 000 and column 7 equals 111, confirming alignment with `video_on`.
- Assert `reset` at h=300, v=200 for 1 clk → all outputs reset asynchronously. The raster restarts at (0,0) with no spurious `frame_start`.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, flag bundle and total-count helpers.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned RGB_W   = 3;

    // 640x480@60 defaults
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    // Sync pulses are active-low for this mode
    localparam logic SYNC_POL_DEF = 1'b0;

    // Raw per-coordinate flags, carried through the renderer-latency pipe
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_flags_t;

    function automatic int unsigned h_total_calc(input int unsigned vis, input int unsigned front,
                                                 input int unsigned sync, input int unsigned back);
        return vis + front + sync + back;
    endfunction

    function automatic int unsigned v_total_calc(input int unsigned vis, input int unsigned front,
                                                 input int unsigned sync, input int unsigned back);
        return vis + front + sync + back;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register with asynchronous clear; depth 0 is a wire.
module sync_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Advance one stage per enable, cleared to inactive on reset
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel divider, h/v counters, latency-matched sync and colour outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT    = H_FRONT_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BACK     = H_BACK_DEF,
    parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT    = V_FRONT_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BACK     = V_BACK_DEF,
    parameter logic        SYNC_POL   = SYNC_POL_DEF,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RGB_W-1:0]   PIXEL,
    output logic [COORD_W-1:0] PIXEL_H,
    output logic [COORD_W-1:0] PIXEL_V,
    output logic               pixel_tick,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [RGB_W-1:0]   rgb
);

    localparam int unsigned H_TOTAL = h_total_calc(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total_calc(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_END  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               w_tick;
    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic               r_frame_start;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic [RGB_W-1:0]   r_rgb;
    sync_flags_t        w_raw;
    sync_flags_t        w_dly;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] r_div_cnt;

            // Pixel-rate divider, wraps at CLK_DIV-1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_div_cnt <= '0;
                end else if (r_div_cnt == DIV_LAST) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end

            assign w_tick = (r_div_cnt == DIV_LAST);
        end else begin : g_nodiv
            assign w_tick = 1'b1;
        end
    endgenerate

    // Raster counters: h wraps each line, v advances on h wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + COORD_W'(1);
            end else begin
                r_h <= r_h + COORD_W'(1);
            end
        end
    end

    // Single-clk pulse coinciding with the counters landing on (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && (r_h == H_LAST) && (r_v == V_LAST);
        end
    end

    // Undelayed flags for the current coordinate
    always_comb begin
        w_raw     = '0;
        w_raw.hs  = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
        w_raw.vs  = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
        w_raw.vis = (r_h < H_VIS_END) && (r_v < V_VIS_END);
    end

    sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH ($bits(sync_flags_t))
    ) u_delay (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_tick),
        .i_d   (w_raw),
        .o_q   (w_dly)
    );

    // Final output stage shared by flags and colour so all four stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync    <= ~SYNC_POL;
            r_vsync    <= ~SYNC_POL;
            r_video_on <= 1'b0;
            r_rgb      <= '0;
        end else if (w_tick) begin
            r_hsync    <= w_dly.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync    <= w_dly.vs ? SYNC_POL : ~SYNC_POL;
            r_video_on <= w_dly.vis;
            r_rgb      <= w_dly.vis ? PIXEL : '0;
        end
    end

    assign PIXEL_H     = r_h;
    assign PIXEL_V     = r_v;
    assign pixel_tick  = w_tick;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign rgb         = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default horizontal timing, 8-line frame to keep runtime short.
module tb_vga_sync_gen;

    // H_TOTAL = 800, V_TOTAL = 4+1+2+1 = 8, frame = 800*8*2 clks
    localparam int FRAME_CLKS = 12800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  PIXEL;
    logic [10:0] PIXEL_H;
    logic [10:0] PIXEL_V;
    logic        pixel_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [2:0]  rgb;

    logic        pix_mode = 1'b0;
    logic [2:0]  r_font = 3'b000;
    int          total = 0;
    int          bad = 0;

    vga_sync_gen #(
        .CLK_DIV    (2),
        .H_VISIBLE  (640),
        .H_FRONT    (16),
        .H_SYNC     (96),
        .H_BACK     (48),
        .V_VISIBLE  (4),
        .V_FRONT    (1),
        .V_SYNC     (2),
        .V_BACK     (1),
        .SYNC_POL   (1'b0),
        .PIPE_DELAY (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PIXEL       (PIXEL),
        .PIXEL_H     (PIXEL_H),
        .PIXEL_V     (PIXEL_V),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .rgb         (rgb)
    );

    always #10 clk = ~clk;

    // Renderer model: colour = column low bits, registered on the pixel tick
    always @(posedge clk) if (pixel_tick) r_font <= PIXEL_H[2:0];
    assign PIXEL = pix_mode ? r_font : 3'b101;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_h"},     32'(PIXEL_H), 32'd0);
        chk({tag, "_v"},     32'(PIXEL_V), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_vis"},   32'(video_on), 32'd0);
        chk({tag, "_rgb"},   32'(rgb), 32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_tick"},  32'(pixel_tick), 32'd0);
    endtask

    // Runs n_clk clks from reset release, checking raster, sync widths, visible runs and frame pulses
    task automatic scan(input int n_clk, input int exp_fs);
        int          fs_n = 0;
        int          fs_prev = 0;
        logic [10:0] ph = 11'd0;
        logic [10:0] pv = 11'd0;
        logic [10:0] v_exp;
        bit          have_prev = 0;
        bit          hs_prev = 1, vs_prev = 1, vis_prev = 0;
        bit          hs_first = 1, vs_first = 1, vis_first = 1;
        int          hs_run = 0, vs_run = 0, vis_run = 0, vis_rgb = 0, leak = 0;
        for (int c = 0; c < n_clk; c++) begin
            @(negedge clk);
            if (c < 6) begin
                chk("start_h", 32'(PIXEL_H), 32'((c + 1) / 2));
                chk("start_tick", 32'(pixel_tick), 32'(c % 2 == 0));
            end
            if (frame_start) begin
                chk("fs_coord", {10'd0, PIXEL_H, PIXEL_V}, 32'd0);
                if (fs_n == 0) chk("fs_first_cyc", 32'(c), 32'(FRAME_CLKS - 1));
                else           chk("fs_period", 32'(c - fs_prev), 32'(FRAME_CLKS));
                fs_prev = c;
                fs_n++;
            end
            if (pixel_tick) begin
                if (have_prev && ph == 11'd799) begin
                    v_exp = (pv == 11'd7) ? 11'd0 : pv + 11'd1;
                    chk("h_wrap", 32'(PIXEL_H), 32'd0);
                    chk("v_step", 32'(PIXEL_V), 32'(v_exp));
                end
                if (!hsync) begin
                    if (hs_prev) begin
                        if (hs_first) chk("hs_start_h", 32'(PIXEL_H), 32'd658);
                        hs_first = 0;
                        hs_run = 0;
                    end
                    hs_run++;
                end else if (!hs_prev) begin
                    chk("hs_width", 32'(hs_run), 32'd96);
                end
                hs_prev = hsync;
                if (!vsync) begin
                    if (vs_prev) begin
                        if (vs_first) begin
                            chk("vs_start_v", 32'(PIXEL_V), 32'd5);
                            chk("vs_start_h", 32'(PIXEL_H), 32'd2);
                        end
                        vs_first = 0;
                        vs_run = 0;
                    end
                    vs_run++;
                end else if (!vs_prev) begin
                    chk("vs_width", 32'(vs_run), 32'd1600);
                end
                vs_prev = vsync;
                if (video_on) begin
                    if (!vis_prev) begin
                        if (vis_first) begin
                            chk("vis_start_h", 32'(PIXEL_H), 32'd2);
                            chk("vis_start_v", 32'(PIXEL_V), 32'd0);
                        end
                        vis_first = 0;
                        vis_run = 0;
                        vis_rgb = 0;
                    end
                    vis_run++;
                    if (rgb == 3'b101) vis_rgb++;
                end else begin
                    if (vis_prev) begin
                        chk("vis_width", 32'(vis_run), 32'd640);
                        chk("vis_rgb101", 32'(vis_rgb), 32'd640);
                    end
                    if (rgb != 3'b000) leak++;
                end
                vis_prev = video_on;
                ph = PIXEL_H;
                pv = PIXEL_V;
                have_prev = 1;
            end
        end
        chk("blank_rgb_zero", 32'(leak), 32'd0);
        chk("fs_count", 32'(fs_n), 32'(exp_fs));
    endtask

    initial begin
        bit found;
        bit seen_low;

        reset = 1'b1;
        pix_mode = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;
        scan(2 * FRAME_CLKS + 20, 2);

        // Column alignment with the tick-registered renderer
        pix_mode = 1'b1;
        found = 0;
        seen_low = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (!video_on) seen_low = 1;
            else if (seen_low) begin
                found = 1;
                break;
            end
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL vis_rise_wait: observed=timeout expected=video_on rise");
        end
        chk("col0_rgb", 32'(rgb), 32'd0);
        chk("col0_vis", 32'(video_on), 32'd1);
        repeat (2) @(negedge clk);
        chk("col1_rgb", 32'(rgb), 32'd1);
        repeat (12) @(negedge clk);
        chk("col7_rgb", 32'(rgb), 32'd7);
        chk("col7_vis", 32'(video_on), 32'd1);

        // Mid-frame reset at (300,2)
        found = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (PIXEL_H == 11'd300 && PIXEL_V == 11'd2) begin
                found = 1;
                break;
            end
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL mid_wait: observed=timeout expected=coordinate (300,2)");
        end
        chk("pre_rst_rgb", 32'(rgb), 32'd2);
        chk("pre_rst_vis", 32'(video_on), 32'd1);
        pix_mode = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("async");
        @(posedge clk);
        @(negedge clk);
        chk_reset("held");
        reset = 1'b0;
        scan(FRAME_CLKS + 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
